// File: rtl/uart_tx_fifo.sv
// UART transmitter with a small TX FIFO. Words are serialised LSB first
// with a start bit, optional even/odd parity and one or two stop bits.
// Divisor, parity mode and stop count are captured when a word leaves the
// FIFO, so changing them mid-frame affects only the following frames.
module uart_tx_fifo #(
   parameter int DATA_BITS  = 8,
   parameter int FIFO_DEPTH = 4,
   parameter int DIV_WIDTH  = 8
) (
   input  logic                         clock,
   input  logic                         reset,
   input  logic [DATA_BITS-1:0]         wr_data,
   input  logic                         wr_en,
   input  logic [DIV_WIDTH-1:0]         baud_division,
   input  logic [1:0]                   parity_mode,
   input  logic                         two_stop,
   output logic                         uart_tx,
   output logic                         busy,
   output logic                         full,
   output logic [$clog2(FIFO_DEPTH):0]  fifo_count,
   output logic                         overflow
);

   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int CW = PW + 1;
   localparam int BW = $clog2(DATA_BITS + 1);

   typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

   logic [DATA_BITS-1:0] mem [FIFO_DEPTH];

   state_t               state_reg, state_next;
   logic [DIV_WIDTH-1:0] baud_cnt_reg, baud_cnt_next;
   logic [DIV_WIDTH-1:0] div_reg, div_next;
   logic [BW-1:0]        bit_cnt_reg, bit_cnt_next;
   logic [DATA_BITS-1:0] shift_reg, shift_next;
   logic                 par_bit_reg, par_bit_next;
   logic                 par_en_reg, par_en_next;
   logic                 two_stop_reg, two_stop_next;
   logic [PW-1:0]        rd_ptr_reg, rd_ptr_next;
   logic [PW-1:0]        wr_ptr_reg, wr_ptr_next;
   logic [CW-1:0]        count_reg, count_next;
   logic                 tx_reg, busy_reg, overflow_reg;

   logic pop, wr_ok, bit_end, tx_bit;

   // full is taken from the pre-edge count, so a write on a full FIFO is
   // dropped even if a pop happens on the same edge.
   assign full       = (count_reg == CW'(FIFO_DEPTH));
   assign wr_ok      = wr_en && !full;
   assign uart_tx    = tx_reg;
   assign busy       = busy_reg;
   assign fifo_count = count_reg;
   assign overflow   = overflow_reg;

   // FIFO storage write port; entries need no reset because the pointers do.
   always_ff @(posedge clock) begin
      if (wr_ok)
         mem[wr_ptr_reg] <= wr_data;
   end

   // Next-state, datapath and line-level bit selection for the frame FSM.
   always_comb begin
      state_next    = state_reg;
      baud_cnt_next = baud_cnt_reg;
      div_next      = div_reg;
      bit_cnt_next  = bit_cnt_reg;
      shift_next    = shift_reg;
      par_bit_next  = par_bit_reg;
      par_en_next   = par_en_reg;
      two_stop_next = two_stop_reg;
      rd_ptr_next   = rd_ptr_reg;
      pop           = 1'b0;
      tx_bit        = 1'b1;
      bit_end       = (baud_cnt_reg == div_reg);

      case (state_reg)
         S_IDLE: begin
            baud_cnt_next = '0;
            if (count_reg != '0)
               pop = 1'b1;
         end
         S_START: begin
            tx_bit = 1'b0;
            if (bit_end) begin
               baud_cnt_next = '0;
               bit_cnt_next  = '0;
               state_next    = S_DATA;
            end else begin
               baud_cnt_next = baud_cnt_reg + DIV_WIDTH'(1);
            end
         end
         S_DATA: begin
            tx_bit = shift_reg[0];
            if (bit_end) begin
               baud_cnt_next = '0;
               shift_next    = {1'b0, shift_reg[DATA_BITS-1:1]};
               if (bit_cnt_reg == BW'(DATA_BITS - 1)) begin
                  bit_cnt_next = '0;
                  state_next   = par_en_reg ? S_PARITY : S_STOP;
               end else begin
                  bit_cnt_next = bit_cnt_reg + BW'(1);
               end
            end else begin
               baud_cnt_next = baud_cnt_reg + DIV_WIDTH'(1);
            end
         end
         S_PARITY: begin
            tx_bit = par_bit_reg;
            if (bit_end) begin
               baud_cnt_next = '0;
               bit_cnt_next  = '0;
               state_next    = S_STOP;
            end else begin
               baud_cnt_next = baud_cnt_reg + DIV_WIDTH'(1);
            end
         end
         S_STOP: begin
            tx_bit = 1'b1;
            if (bit_end) begin
               baud_cnt_next = '0;
               if (two_stop_reg && bit_cnt_reg == '0) begin
                  bit_cnt_next = BW'(1);
               end else if (count_reg != '0) begin
                  pop = 1'b1;
               end else begin
                  state_next = S_IDLE;
               end
            end else begin
               baud_cnt_next = baud_cnt_reg + DIV_WIDTH'(1);
            end
         end
         default: state_next = S_IDLE;
      endcase

      // Loading a frame: capture the word, its parity and the line settings.
      if (pop) begin
         state_next    = S_START;
         baud_cnt_next = '0;
         bit_cnt_next  = '0;
         shift_next    = mem[rd_ptr_reg];
         par_bit_next  = (^mem[rd_ptr_reg]) ^ parity_mode[1];
         par_en_next   = ^parity_mode;
         two_stop_next = two_stop;
         div_next      = baud_division;
         rd_ptr_next   = rd_ptr_reg + PW'(1);
      end

      wr_ptr_next = wr_ok ? wr_ptr_reg + PW'(1) : wr_ptr_reg;
      count_next  = count_reg + CW'(wr_ok) - CW'(pop);
   end

   // State and datapath registers; the line and busy are registered from
   // the current state so they lag the FSM by exactly one clock.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_reg    <= S_IDLE;
         baud_cnt_reg <= '0;
         div_reg      <= '0;
         bit_cnt_reg  <= '0;
         shift_reg    <= '0;
         par_bit_reg  <= 1'b0;
         par_en_reg   <= 1'b0;
         two_stop_reg <= 1'b0;
         rd_ptr_reg   <= '0;
         wr_ptr_reg   <= '0;
         count_reg    <= '0;
         tx_reg       <= 1'b1;
         busy_reg     <= 1'b0;
         overflow_reg <= 1'b0;
      end else begin
         state_reg    <= state_next;
         baud_cnt_reg <= baud_cnt_next;
         div_reg      <= div_next;
         bit_cnt_reg  <= bit_cnt_next;
         shift_reg    <= shift_next;
         par_bit_reg  <= par_bit_next;
         par_en_reg   <= par_en_next;
         two_stop_reg <= two_stop_next;
         rd_ptr_reg   <= rd_ptr_next;
         wr_ptr_reg   <= wr_ptr_next;
         count_reg    <= count_next;
         tx_reg       <= tx_bit;
         busy_reg     <= (state_reg != S_IDLE) || (count_reg != '0);
         overflow_reg <= wr_en && full;
      end
   end

endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
Parametrised next-generation UART transmitter for the FPGA motor/peripheral link.
- Adds a TX FIFO, configurable data width, runtime parity (none/even/odd) and 1 or 2 stop bits.
- Host logic pushes words with a write strobe; the block serialises them back-to-back, LSB first, at a runtime-programmable baud divisor.
- Drives one pin-level TX line; board-level fan-out stays outside this block.

Parameters:
DATA_BITS, 8, data bits per frame (5..8)
FIFO_DEPTH, 4, FIFO entries (power of two, >=2)
DIV_WIDTH, 8, width of baud_division

Ports:
clock  input  1  system clock, all logic on rising edge
reset  input  1  synchronous reset, active-high
wr_data  input  DATA_BITS  word to enqueue
wr_en  input  1  enqueue strobe, one word per cycle high
baud_division  input  DIV_WIDTH  clocks per bit minus 1
parity_mode  input  2  00 none, 01 even, 10 odd, 11 none
two_stop  input  1  1 = two stop bits, 0 = one stop bit
uart_tx  output  1  serial line, registered, idles high
busy  output  1  frame in progress or FIFO non-empty
full  output  1  FIFO holds FIFO_DEPTH words
fifo_count  output  clog2(FIFO_DEPTH)+1  words queued, excluding the frame being sent
overflow  output  1  one-cycle pulse, write dropped

Behaviour:
- Interface: one clock, `clock`; reset, `reset`, is synchronous and active-high.
- Reset, sampled on a clock edge, forces the following state. It has priority over all other inputs, including mid-frame; no partial frame resumes.
  - uart_tx=1, busy=0, full=0, fifo_count=0, overflow=0.
  - FIFO pointers cleared and FSM in IDLE.
- FIFO write:
  - wr_en with full=0 stores wr_data at the edge.
  - wr_en with full=1 drops the word and pulses overflow for exactly one cycle. This holds even if a pop occurs on the same edge, because full is evaluated pre-edge.
  - A simultaneous write and pop leaves fifo_count unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
- Pop: occurs only when the FSM loads a frame. The popped word goes to the shift register and fifo_count decrements.
- Bit timing:
  - Each bit lasts baud_division+1 clocks. baud_division=0 gives 1 clock per bit.
  - baud_division, parity_mode and two_stop are latched at pop. Changes mid-frame affect only the next frame.
- FSM states and transitions:
  - IDLE: if FIFO non-empty, pop → START.
  - START: uart_tx=0 for 1 bit → DATA.
  - DATA: DATA_BITS bits, LSB first. After the last bit → PARITY if the latched mode is even/odd, else → STOP.
  - PARITY: even mode sends XOR of the data bits; odd mode sends its inverse → STOP.
  - STOP: uart_tx=1 for 1 or 2 bits. At the final clock of the last stop bit: if FIFO non-empty, pop → START; else → IDLE.
- Latency: a word written at edge E into an empty FIFO with FSM in IDLE pops at E+1. uart_tx falls at E+2.
- Back-to-back frames: no idle gap. The next start bit begins the clock after the last stop bit ends.
- Frame length: (1 + DATA_BITS + P + S) × (baud_division+1) clocks, where P∈{0,1} and S∈{1,2}.
- busy = (state≠IDLE) or (fifo_count≠0), registered.

Test Plan:
- Reset, then idle 20 clocks → uart_tx=1, busy=0, fifo_count=0, full=0, overflow=0.
- DATA_BITS=8, baud_division=3, parity none, one stop; write 0x47 → uart_tx falls 2 clocks after the write edge. Bit sequence is 0,1,1,1,0,0,0,1,0,1, each bit 4 clocks, 40 clocks total; then busy=0.
- Same byte 0x47, parity variants:
  - Even parity → parity bit 0, frame 44 clocks.
  - Odd parity → parity bit 1.
  - Odd parity with two_stop=1 → 48 clocks, the last 8 high.
- Write 0x55, 0xAA, 0x0F in 3 consecutive cycles (none, one stop, baud_division=1) → three 20-clock frames, contiguous with no idle cycle. fifo_count peaks at 2; busy falls one clock after the final stop bit.
- FIFO_DEPTH=4, baud_division=200; write 6 words on consecutive cycles → word 1 pops, full asserts after write 5, and write 6 pulses overflow once. Words 1–5 are transmitted in order; word 6 is never transmitted.
- Reset asserted mid-DATA of frame 1 with 2 words queued → the next edge gives uart_tx=1, fifo_count=0, busy=0. No frame appears afterwards; a new write of 0x3C then transmits correctly.
